// File: rtl/bit_gather.sv
// bit_gather: packs BEATS beats of LANES single-bit lanes into one WIDTH-bit
// word. Beat n lands at out_data[n*LANES +: LANES], so beat 0 is in the LSBs.
// A flush emits a partial word, zero-padded, with out_beats = beats held.
// The beat counter cnt is the fill state:
//   state | meaning
//   EMPTY | cnt == 0, the accumulator holds no beats
//   FILL  | 0 < cnt < BEATS, a partial word is being collected
// The output register carries its own valid flag. A consume and a load in the
// same cycle swap the word without a bubble.
// Optional build macro BIT_GATHER_PARITY_EN adds out_parity, which is the XOR
// of all out_data bits and is registered alongside out_data.
module bit_gather #(
  parameter  int LANES = 12,
  parameter  int BEATS = 4,
  localparam int WIDTH = LANES * BEATS,
  localparam int CW    = $clog2(BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LANES-1:0] in_bits,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_beats,
  output logic             out_valid,
  input  logic             out_ready
`ifdef BIT_GATHER_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FILL  = 1'b1
  } fill_state_t;

  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  fill_state_t      state;
  logic [CW-1:0]    cnt, cnt_d;
  logic [WIDTH-1:0] acc, acc_d;
  logic [WIDTH-1:0] merged;
  logic [WIDTH-1:0] out_data_d;
  logic [CW-1:0]    out_beats_d;
  logic [CW-1:0]    beats_now;
  logic             out_valid_d;
  logic             out_free;
  logic             accept;
  logic             complete;
  logic             emit;

  // Decode the fill state, accept beats, and choose the next accumulator and output contents.
  always_comb begin
    state       = (cnt == '0) ? EMPTY : FILL;
    // The output slot is free if it is empty or is being drained this cycle.
    out_free    = !out_valid || out_ready;
    // A non-final beat never needs the output slot, so it is always accepted.
    in_ready    = (cnt < LAST) || out_free;
    accept      = in_valid && in_ready;
    merged      = acc;
    for (int b = 0; b < BEATS; b++) begin
      if (accept && (cnt == CW'(b))) begin
        merged[b*LANES +: LANES] = in_bits;
      end
    end
    complete    = accept && (cnt == LAST);
    // A flush on an empty accumulator with no incoming beat has nothing to emit.
    emit        = complete || (flush && out_free && (accept || (state == FILL)));
    beats_now   = accept ? (cnt + CW'(1)) : cnt;

    cnt_d       = cnt;
    acc_d       = acc;
    out_data_d  = out_data;
    out_beats_d = out_beats;
    out_valid_d = out_valid;

    if (emit) begin
      cnt_d       = '0;
      acc_d       = '0;
      out_data_d  = merged;
      out_beats_d = beats_now;
      out_valid_d = 1'b1;
    end else begin
      if (accept) begin
        cnt_d = cnt + CW'(1);
        acc_d = merged;
      end
      if (out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Register the accumulator, beat counter and output word; reset discards any partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_beats <= '0;
      out_valid <= 1'b0;
    end else begin
      cnt       <= cnt_d;
      acc       <= acc_d;
      out_data  <= out_data_d;
      out_beats <= out_beats_d;
      out_valid <= out_valid_d;
    end
  end

`ifdef BIT_GATHER_PARITY_EN
  // Register the parity of each word as it is loaded into the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_parity <= 1'b0;
    end else if (emit) begin
      out_parity <= ^merged;
    end
  end
`endif

endmodule

// File: doc/bit_gather.md
BIT_GATHER -- requirements
Module: bit_gather

Interface
REQ-001 Parameter LANES, default 12, SHALL set the number of single-bit lanes sampled per beat (1..64).
REQ-002 Parameter BEATS, default 4, SHALL set the number of beats packed per output word (2..16).
REQ-003 Derived WIDTH = LANES*BEATS and CW = clog2(BEATS+1) SHALL be localparams, not overridable.
REQ-004 Ports (name, direction, width, meaning) SHALL be exactly:
- clk      in   1      single clock; all state on rising edge
- rst_n    in   1      asynchronous, active-low reset
- in_bits  in   LANES  lane bits; bit k is lane k
- in_valid in   1      in_bits valid this cycle
- in_ready out  1      beat accepted when in_valid && in_ready
- flush    in   1      emit a partial word
- out_data out  WIDTH  packed word
- out_beats out CW     number of valid beats in out_data (1..BEATS)
- out_valid out 1      out_data/out_beats valid
- out_ready in  1      word consumed when out_valid && out_ready

Function
REQ-005 Beat n (0-based) of a word SHALL occupy out_data[n*LANES+LANES-1 : n*LANES], with lane k at bit n*LANES+k; beat 0 is in the LSBs.
REQ-006 The block SHALL hold one accumulator register (WIDTH bits) plus beat counter cnt (0..BEATS-1), and one output register.
REQ-007 State machine SHALL be EMPTY (cnt==0), FILL (0<cnt<BEATS), derived from cnt; output register independently holds VALID/INVALID.
REQ-008 in_ready SHALL be 1 when cnt<BEATS-1, or when out_valid==0, or when out_ready==1 (combinational from out_ready allowed).
REQ-009 An accepted beat with cnt<BEATS-1 SHALL write its lanes into the accumulator and increment cnt; no output change.
REQ-010 An accepted beat with cnt==BEATS-1 SHALL load the completed word into the output register next edge with out_beats=BEATS, set out_valid, clear cnt to 0 and the accumulator to 0.
REQ-011 Latency: the final beat of a word accepted at edge t SHALL appear on out_data at edge t (valid after that edge); one-cycle registered path.
REQ-012 flush with cnt>0 and no beat accepted SHALL emit the partial word (unused beats zero) with out_beats=cnt, once the output register is free or draining that cycle; flush SHALL be held by the source until emitted.
REQ-013 flush with cnt==0 and no beat accepted SHALL be ignored.
REQ-014 flush coincident with an accepted beat SHALL include that beat, then emit with out_beats=cnt+1 (or BEATS if completing).
REQ-015 out_valid SHALL stay high and out_data/out_beats stable until out_ready; a consume with no new word SHALL clear out_valid.
REQ-016 Consume and load in the same cycle SHALL replace the word with no bubble; full throughput is one beat per cycle.
REQ-017 in_valid low SHALL leave the accumulator and cnt unchanged; in_bits are don't-care.

Reset
REQ-018 rst_n low SHALL asynchronously clear cnt, accumulator, out_data, out_beats and out_valid to 0; in_ready SHALL read 1.
REQ-019 Reset mid-word SHALL discard the partial word; no flush output after release.
REQ-020 Release SHALL be honoured on the first rising clk after rst_n rises.

Configuration
REQ-021 Macro BIT_GATHER_PARITY_EN defined SHALL add output out_parity (1 bit) = XOR of all out_data bits, registered with out_data, reset 0.
REQ-022 Without BIT_GATHER_PARITY_EN the out_parity port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-023 LANES=12,BEATS=4, out_ready=1, beats 0x001,0x002,0x004,0x800 back-to-back -> one out_valid cycle with out_data=0x800004002001, out_beats=4.
REQ-024 Same, out_ready=0 after first word, 8 more beats -> in_ready low on beat 8 (cnt==3) until out_ready=1; no word lost or reordered.
REQ-025 Two beats 0xFFF,0x0AA then flush -> out_data=0x000000 0AAFFF (zero-padded, 48 bits), out_beats=2; flush with cnt==0 -> no output.
REQ-026 Assert rst_n low after 3 beats, release, send 4 beats 0x111 each -> out_data=0x111111111111, out_beats=4; stale beats absent.
REQ-027 With BIT_GATHER_PARITY_EN, word 0x000000000007 -> out_parity=1; word 0x000000000003 -> out_parity=0.
